// File: rtl/awg_pkg.sv
// Shared wave/field codes for the AWG front panel (awg_ctrl) and sig_gen.
// Helper functions give the next waveform and the next selected field.
package awg_pkg;

    typedef enum logic [4:0] {
        WAVE_SAW = 5'd0,
        WAVE_TRI = 5'd1,
        WAVE_SQR = 5'd2,
        WAVE_SIN = 5'd3,
        WAVE_OFF = 5'd10
    } wave_e;

    typedef enum logic [1:0] {
        FLD_FREQ  = 2'd0,
        FLD_AMP   = 2'd1,
        FLD_PHASE = 2'd2
    } field_e;

    function automatic wave_e nextWave(input wave_e w);
        case (w)
            WAVE_SAW: nextWave = WAVE_TRI;
            WAVE_TRI: nextWave = WAVE_SQR;
            WAVE_SQR: nextWave = WAVE_SIN;
            WAVE_SIN: nextWave = WAVE_OFF;
            default:  nextWave = WAVE_SAW;
        endcase
    endfunction

    function automatic field_e nextField(input field_e f);
        case (f)
            FLD_FREQ: nextField = FLD_AMP;
            FLD_AMP:  nextField = FLD_PHASE;
            default:  nextField = FLD_FREQ;
        endcase
    endfunction

endpackage

// File: rtl/awg_debounce.sv
// One push key: 2-FF synchroniser, stability counter and press (1->0) detector.
// The debounced level resets to "pressed" so a key held through reset must be released first.
module awg_debounce
    import awg_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 20'd1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;

    // sync_q[1] is the synchronised level; a mismatch with sync_q[0] means it is about to change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            press_q <= 1'b0;
            if (sync_q[1] != sync_q[0]) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                press_q <= level_q & ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/awg_ctrl.sv
// Front-panel control for sig_gen: debounced keys drive waveform/field FSMs and value registers.
// Define AWG_AUTO_CYCLE_EN to add a free-running counter that advances the waveform every AUTO_PERIOD cycles.
module awg_ctrl
    import awg_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
    parameter logic [11:0] FREQ_RST     = 12'd1,
    parameter logic [11:0] FREQ_MAX     = 12'hFFF,
    parameter logic [11:0] FREQ_STEP    = 12'd1,
    parameter logic [7:0]  PHASE_STEP   = 8'd8
`ifdef AWG_AUTO_CYCLE_EN
    ,
    parameter logic [25:0] AUTO_PERIOD  = 26'd50000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_wave_n,
    input  logic        key_sel_n,
    input  logic        key_up_n,
    input  logic        key_down_n,
    output logic [4:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  sel_field,
    output logic        param_chg
);

    logic pressWave, pressSel, pressUp, pressDown;

    awg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbWave (.clk(clk), .rst_n(rst_n), .key_n(key_wave_n), .press(pressWave));
    awg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbSel  (.clk(clk), .rst_n(rst_n), .key_n(key_sel_n),  .press(pressSel));
    awg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbUp   (.clk(clk), .rst_n(rst_n), .key_n(key_up_n),   .press(pressUp));
    awg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbDown (.clk(clk), .rst_n(rst_n), .key_n(key_down_n), .press(pressDown));

    wave_e       wave_q, wave_d;
    field_e      fld_q, fld_d;
    logic [11:0] freq_q, freq_d;
    logic [2:0]  amp_q, amp_d;
    logic [7:0]  phase_q, phase_d;
    logic        chg_q, chg_d;
    logic        waveAdv, adjUp, adjDown;
    logic [12:0] freqSum, freqDiff;

`ifdef AWG_AUTO_CYCLE_EN
    logic [25:0] autoCnt_q;
    logic        autoTick;

    assign autoTick = (autoCnt_q == AUTO_PERIOD - 26'd1);
    // A manual press restarts the period; press and tick together still advance only once
    assign waveAdv  = pressWave | autoTick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            autoCnt_q <= '0;
        end else if (pressWave || autoTick) begin
            autoCnt_q <= '0;
        end else begin
            autoCnt_q <= autoCnt_q + 26'd1;
        end
    end
`else
    assign waveAdv = pressWave;
`endif

    // Edits apply to the field selected before any same-cycle sel press
    always_comb begin
        wave_d   = wave_q;
        fld_d    = fld_q;
        freq_d   = freq_q;
        amp_d    = amp_q;
        phase_d  = phase_q;
        adjUp    = pressUp & ~pressDown;
        adjDown  = pressDown & ~pressUp;
        freqSum  = {1'b0, freq_q} + {1'b0, FREQ_STEP};
        freqDiff = {1'b0, freq_q} - {1'b0, FREQ_STEP};
        if (waveAdv) begin
            wave_d = nextWave(wave_q);
        end
        case (fld_q)
            FLD_FREQ: begin
                if (adjUp) begin
                    freq_d = (freqSum > {1'b0, FREQ_MAX}) ? FREQ_MAX : freqSum[11:0];
                end else if (adjDown) begin
                    freq_d = freqDiff[12] ? 12'd0 : freqDiff[11:0];
                end
            end
            FLD_AMP: begin
                if (adjUp && amp_q != 3'd7) begin
                    amp_d = amp_q + 3'd1;
                end else if (adjDown && amp_q != 3'd0) begin
                    amp_d = amp_q - 3'd1;
                end
            end
            FLD_PHASE: begin
                if (adjUp) begin
                    phase_d = phase_q + PHASE_STEP;
                end else if (adjDown) begin
                    phase_d = phase_q - PHASE_STEP;
                end
            end
            default: ;
        endcase
        if (pressSel) begin
            fld_d = nextField(fld_q);
        end
        chg_d = (wave_d != wave_q) | (fld_d != fld_q) | (freq_d != freq_q) |
                (amp_d != amp_q) | (phase_d != phase_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_q  <= WAVE_SAW;
            fld_q   <= FLD_FREQ;
            freq_q  <= FREQ_RST;
            amp_q   <= 3'd7;
            phase_q <= 8'd0;
            chg_q   <= 1'b0;
        end else begin
            wave_q  <= wave_d;
            fld_q   <= fld_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
            chg_q   <= chg_d;
        end
    end

    assign state       = wave_q;
    assign state_freq  = freq_q;
    assign state_amp   = amp_q;
    assign state_phase = phase_q;
    assign sel_field   = fld_q;
    assign param_chg   = chg_q;

endmodule

// File: tb/tb_awg_ctrl.sv
// Directed bench for awg_ctrl with DEBOUNCE_CYC=16; a second instance starts at FREQ_MAX.
// With AWG_AUTO_CYCLE_EN a third instance (AUTO_PERIOD=100) exercises the auto advance.
module tb_awg_ctrl;

    localparam logic [3:0] K_WAVE = 4'b0001;
    localparam logic [3:0] K_SEL  = 4'b0010;
    localparam logic [3:0] K_UP   = 4'b0100;
    localparam logic [3:0] K_DOWN = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  keys_n = 4'hF;
    logic [3:0]  keys2_n = 4'hF;
    int          errors = 0;
    int          checks = 0;

    logic [4:0]  state, state2;
    logic [11:0] state_freq, state_freq2;
    logic [2:0]  state_amp, state_amp2;
    logic [7:0]  state_phase, state_phase2;
    logic [1:0]  sel_field, sel_field2;
    logic        param_chg, param_chg2;

    always #5 clk = ~clk;

    awg_ctrl #(.DEBOUNCE_CYC(20'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wave_n(keys_n[0]), .key_sel_n(keys_n[1]), .key_up_n(keys_n[2]), .key_down_n(keys_n[3]),
        .state(state), .state_freq(state_freq), .state_amp(state_amp), .state_phase(state_phase),
        .sel_field(sel_field), .param_chg(param_chg)
    );

    awg_ctrl #(.DEBOUNCE_CYC(20'd16), .FREQ_RST(12'hFFF)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .key_wave_n(keys2_n[0]), .key_sel_n(keys2_n[1]), .key_up_n(keys2_n[2]), .key_down_n(keys2_n[3]),
        .state(state2), .state_freq(state_freq2), .state_amp(state_amp2), .state_phase(state_phase2),
        .sel_field(sel_field2), .param_chg(param_chg2)
    );

`ifdef AWG_AUTO_CYCLE_EN
    logic        rstA_n = 1'b0;
    logic        keyA_n = 1'b1;
    logic [4:0]  stateA;
    logic [11:0] freqA;
    logic [2:0]  ampA;
    logic [7:0]  phaseA;
    logic [1:0]  selA;
    logic        chgA;

    awg_ctrl #(.DEBOUNCE_CYC(20'd16), .AUTO_PERIOD(26'd100)) dut3 (
        .clk(clk), .rst_n(rstA_n),
        .key_wave_n(keyA_n), .key_sel_n(1'b1), .key_up_n(1'b1), .key_down_n(1'b1),
        .state(stateA), .state_freq(freqA), .state_amp(ampA), .state_phase(phaseA),
        .sel_field(selA), .param_chg(chgA)
    );
`endif

    // Hold the masked keys low for 24 cycles, release for 24, counting param_chg pulses
    task automatic pressKeys(input int unit, input logic [3:0] mask, output int chg);
        chg = 0;
        if (unit == 0) keys_n = ~mask; else keys2_n = ~mask;
        repeat (24) begin
            @(negedge clk);
            if ((unit == 0 ? param_chg : param_chg2) === 1'b1) chg++;
        end
        keys_n  = 4'hF;
        keys2_n = 4'hF;
        repeat (24) begin
            @(negedge clk);
            if ((unit == 0 ? param_chg : param_chg2) === 1'b1) chg++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 5'd0) begin errors++; $display("[TB] FAIL rst_state got %0d want 0", state); end
        checks++; if (state_freq !== 12'd1) begin errors++; $display("[TB] FAIL rst_freq got %0d want 1", state_freq); end
        checks++; if (state_amp !== 3'd7) begin errors++; $display("[TB] FAIL rst_amp got %0d want 7", state_amp); end
        checks++; if (state_phase !== 8'd0) begin errors++; $display("[TB] FAIL rst_phase got %0d want 0", state_phase); end
        checks++; if (sel_field !== 2'd0) begin errors++; $display("[TB] FAIL rst_sel got %0d want 0", sel_field); end
        checks++; if (param_chg !== 1'b0) begin errors++; $display("[TB] FAIL rst_chg got %0d want 0", param_chg); end
        checks++; if (state_freq2 !== 12'hFFF) begin errors++; $display("[TB] FAIL rst_freq2 got %0h want fff", state_freq2); end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (param_chg !== 1'b0) begin errors++; $display("[TB] FAIL settle_chg got %0d want 0", param_chg); end
    endtask

    task automatic test_wave();
        int chg;
        int found;
        logic [4:0] seq [4];
        seq = '{5'd2, 5'd3, 5'd10, 5'd0};
        chg = 0;
        found = 0;
        keys_n = ~K_WAVE;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (param_chg === 1'b1) chg++;
            if (state === 5'd1) begin
                found = i;
                break;
            end
        end
        checks++; if (found == 0) begin errors++; $display("[TB] FAIL wave_latency got state %0d want 1 within 20 cycles", state); end
        repeat (10) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
        keys_n = 4'hF;
        repeat (30) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
        checks++; if (chg != 1) begin errors++; $display("[TB] FAIL wave_chg got %0d pulses want 1", chg); end
        checks++; if (state !== 5'd1) begin errors++; $display("[TB] FAIL wave_first got %0d want 1", state); end
        for (int k = 0; k < 4; k++) begin
            pressKeys(0, K_WAVE, chg);
            checks++; if (state !== seq[k]) begin errors++; $display("[TB] FAIL wave_seq%0d got %0d want %0d", k, state, seq[k]); end
            checks++; if (chg != 1) begin errors++; $display("[TB] FAIL wave_seq%0d_chg got %0d want 1", k, chg); end
        end
    endtask

    task automatic test_glitch();
        int chg;
        chg = 0;
        repeat (10) begin
            keys_n = ~K_UP;
            repeat (5) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
            keys_n = 4'hF;
            repeat (5) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
        end
        repeat (30) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
        checks++; if (chg != 0) begin errors++; $display("[TB] FAIL glitch_chg got %0d want 0", chg); end
        checks++; if (state_freq !== 12'd1) begin errors++; $display("[TB] FAIL glitch_freq got %0d want 1", state_freq); end
        checks++; if (state !== 5'd0 || state_amp !== 3'd7 || state_phase !== 8'd0 || sel_field !== 2'd0) begin
            errors++; $display("[TB] FAIL glitch_outs got %0d/%0d/%0d/%0d want 0/7/0/0", state, state_amp, state_phase, sel_field);
        end
    endtask

    task automatic test_freq_sat();
        int chg;
        pressKeys(0, K_DOWN, chg);
        checks++; if (state_freq !== 12'd0) begin errors++; $display("[TB] FAIL freq_down got %0d want 0", state_freq); end
        checks++; if (chg != 1) begin errors++; $display("[TB] FAIL freq_down_chg got %0d want 1", chg); end
        pressKeys(0, K_DOWN, chg);
        checks++; if (state_freq !== 12'd0) begin errors++; $display("[TB] FAIL freq_floor got %0d want 0", state_freq); end
        checks++; if (chg != 0) begin errors++; $display("[TB] FAIL freq_floor_chg got %0d want 0", chg); end
        pressKeys(1, K_UP, chg);
        checks++; if (state_freq2 !== 12'hFFF) begin errors++; $display("[TB] FAIL freq_ceil got %0h want fff", state_freq2); end
        checks++; if (chg != 0) begin errors++; $display("[TB] FAIL freq_ceil_chg got %0d want 0", chg); end
        pressKeys(1, K_DOWN, chg);
        checks++; if (state_freq2 !== 12'hFFE) begin errors++; $display("[TB] FAIL freq_ceil_down got %0h want ffe", state_freq2); end
    endtask

    task automatic test_phase_amp();
        int chg;
        pressKeys(0, K_SEL, chg);
        pressKeys(0, K_SEL, chg);
        checks++; if (sel_field !== 2'd2) begin errors++; $display("[TB] FAIL sel_phase got %0d want 2", sel_field); end
        pressKeys(0, K_DOWN, chg);
        checks++; if (state_phase !== 8'd248) begin errors++; $display("[TB] FAIL phase_wrap_down got %0d want 248", state_phase); end
        pressKeys(0, K_UP, chg);
        checks++; if (state_phase !== 8'd0) begin errors++; $display("[TB] FAIL phase_wrap_up got %0d want 0", state_phase); end
        pressKeys(0, K_UP, chg);
        checks++; if (state_phase !== 8'd8) begin errors++; $display("[TB] FAIL phase_up got %0d want 8", state_phase); end
        pressKeys(0, K_DOWN, chg);
        pressKeys(0, K_DOWN, chg);
        checks++; if (state_phase !== 8'd248) begin errors++; $display("[TB] FAIL phase_down2 got %0d want 248", state_phase); end
        checks++; if (state_freq !== 12'd0 || state_amp !== 3'd7) begin errors++; $display("[TB] FAIL phase_other got %0d/%0d want 0/7", state_freq, state_amp); end
        pressKeys(0, K_SEL, chg);
        pressKeys(0, K_SEL, chg);
        checks++; if (sel_field !== 2'd1) begin errors++; $display("[TB] FAIL sel_amp got %0d want 1", sel_field); end
        pressKeys(0, K_UP, chg);
        checks++; if (state_amp !== 3'd7) begin errors++; $display("[TB] FAIL amp_ceil got %0d want 7", state_amp); end
        checks++; if (chg != 0) begin errors++; $display("[TB] FAIL amp_ceil_chg got %0d want 0", chg); end
        pressKeys(0, K_DOWN, chg);
        checks++; if (state_amp !== 3'd6) begin errors++; $display("[TB] FAIL amp_down got %0d want 6", state_amp); end
        checks++; if (chg != 1) begin errors++; $display("[TB] FAIL amp_down_chg got %0d want 1", chg); end
    endtask

    task automatic test_simultaneous();
        int chg;
        pressKeys(0, K_SEL, chg);
        pressKeys(0, K_SEL, chg);
        pressKeys(0, K_UP, chg);
        checks++; if (state_freq !== 12'd1 || sel_field !== 2'd0) begin errors++; $display("[TB] FAIL simul_prep got %0d/%0d want 1/0", state_freq, sel_field); end
        pressKeys(0, K_SEL | K_UP, chg);
        checks++; if (state_freq !== 12'd2) begin errors++; $display("[TB] FAIL selup_freq got %0d want 2", state_freq); end
        checks++; if (sel_field !== 2'd1) begin errors++; $display("[TB] FAIL selup_sel got %0d want 1", sel_field); end
        pressKeys(0, K_UP | K_DOWN, chg);
        checks++; if (chg != 0) begin errors++; $display("[TB] FAIL updown_chg got %0d want 0", chg); end
        checks++; if (state_amp !== 3'd6 || state_freq !== 12'd2 || sel_field !== 2'd1) begin
            errors++; $display("[TB] FAIL updown_outs got %0d/%0d/%0d want 6/2/1", state_amp, state_freq, sel_field);
        end
    endtask

`ifdef AWG_AUTO_CYCLE_EN
    task automatic test_auto();
        @(negedge clk);
        rstA_n = 1'b1;
        repeat (99) @(negedge clk);
        checks++; if (stateA !== 5'd0) begin errors++; $display("[TB] FAIL auto_pre got %0d want 0", stateA); end
        @(negedge clk);
        checks++; if (stateA !== 5'd1) begin errors++; $display("[TB] FAIL auto_tick1 got %0d want 1", stateA); end
        repeat (100) @(negedge clk);
        checks++; if (stateA !== 5'd2) begin errors++; $display("[TB] FAIL auto_tick2 got %0d want 2", stateA); end
        repeat (81) @(negedge clk);
        keyA_n = 1'b0;
        repeat (19) @(negedge clk);
        checks++; if (stateA !== 5'd3) begin errors++; $display("[TB] FAIL auto_coincide got %0d want 3", stateA); end
        keyA_n = 1'b1;
        repeat (31) @(negedge clk);
        keyA_n = 1'b0;
        repeat (19) @(negedge clk);
        checks++; if (stateA !== 5'd10) begin errors++; $display("[TB] FAIL auto_press got %0d want 10", stateA); end
        keyA_n = 1'b1;
        repeat (99) @(negedge clk);
        checks++; if (stateA !== 5'd10) begin errors++; $display("[TB] FAIL auto_restart got %0d want 10", stateA); end
        @(negedge clk);
        checks++; if (stateA !== 5'd0) begin errors++; $display("[TB] FAIL auto_after_restart got %0d want 0", stateA); end
    endtask
`endif

    task automatic test_reset_mid_press();
        int chg;
        pressKeys(0, K_WAVE, chg);
        checks++; if (state !== 5'd1) begin errors++; $display("[TB] FAIL midrst_prep got %0d want 1", state); end
        keys_n = ~K_WAVE;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 5'd0) begin errors++; $display("[TB] FAIL midrst_state got %0d want 0", state); end
        checks++; if (state_freq !== 12'd1 || state_amp !== 3'd7) begin errors++; $display("[TB] FAIL midrst_freqamp got %0d/%0d want 1/7", state_freq, state_amp); end
        checks++; if (state_phase !== 8'd0 || sel_field !== 2'd0) begin errors++; $display("[TB] FAIL midrst_phasesel got %0d/%0d want 0/0", state_phase, sel_field); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chg = 0;
        repeat (40) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
        keys_n = 4'hF;
        repeat (30) begin @(negedge clk); if (param_chg === 1'b1) chg++; end
        checks++; if (chg != 0 || state !== 5'd0) begin errors++; $display("[TB] FAIL midrst_held got chg %0d state %0d want 0/0", chg, state); end
        pressKeys(0, K_WAVE, chg);
        checks++; if (state !== 5'd1) begin errors++; $display("[TB] FAIL midrst_repress got %0d want 1", state); end
        checks++; if (chg != 1) begin errors++; $display("[TB] FAIL midrst_repress_chg got %0d want 1", chg); end
    endtask

    initial begin
        test_reset();
        test_wave();
        test_glitch();
        test_freq_sat();
        test_phase_amp();
        test_simultaneous();
`ifdef AWG_AUTO_CYCLE_EN
        test_auto();
`endif
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
